// File: rtl/image_ram_loader_if.sv
// -----------------------------------------------------------------------------
// image_ram_loader_if
//   Bundles the control, byte-stream and RAM-write signals of the image RAM
//   loader.
//   master : the side that issues start/abort and sources the byte stream;
//            it observes the RAM write port and the status pulses.
//   slave  : the loader itself.
//   Signals
//     start, abort        frame control requests
//     rx_data, rx_valid   incoming byte stream
//     rx_ready            loader accepts a byte this cycle
//     wr_en/addr/data     image RAM write port, address {y, x}, data {R, G, B}
//     busy, done, error   frame status and one-cycle completion/timeout pulses
// -----------------------------------------------------------------------------
interface image_ram_loader_if;
  logic        start;
  logic        abort;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    output start, abort, rx_data, rx_valid,
    input  rx_ready, wr_en, wr_addr, wr_data, busy, done, error
  );

  modport slave (
    input  start, abort, rx_data, rx_valid,
    output rx_ready, wr_en, wr_addr, wr_data, busy, done, error
  );
endinterface

// File: rtl/image_ram_loader.sv
// -----------------------------------------------------------------------------
// image_ram_loader
//   Writer side of the card-image memory. Accepts a byte stream over a
//   valid/ready handshake, packs each pair of bytes into one 12-bit RGB pixel
//   (first byte supplies R in its low nibble, second byte supplies G and B) and
//   writes the pixel to the image RAM at {y, x}, the same address layout the
//   drawing blocks read.
//   Ports
//     pclk   pixel clock, rising edge
//     rst    synchronous active-high reset
//     bus    image_ram_loader_if.slave: start/abort, rx_data/rx_valid/rx_ready,
//            wr_en/wr_addr/wr_data, busy/done/error
//   Parameters
//     WIDTH, HEIGHT    image size in pixels, 1..256 each
//     TIMEOUT_CYCLES   idle handshake cycles inside a frame before it is
//                      abandoned with an error pulse, >= 2
// -----------------------------------------------------------------------------
module image_ram_loader #(
  parameter int WIDTH          = 200,
  parameter int HEIGHT         = 112,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               pclk,
  input  logic               rst,
  image_ram_loader_if.slave  bus
);

  // The counter only needs to hold 0..TIMEOUT_CYCLES-1: expiry is detected on
  // the cycle that would take it to TIMEOUT_CYCLES.
  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]        X_LAST   = 8'(WIDTH - 1);
  localparam logic [7:0]        Y_LAST   = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  state_t            state_reg,   state_next;
  logic [7:0]        x_reg,       x_next;
  logic [7:0]        y_reg,       y_next;
  logic [3:0]        r_reg,       r_next;
  logic [CNT_W-1:0]  cnt_reg,     cnt_next;
  logic              wr_en_reg,   wr_en_next;
  logic [15:0]       wr_addr_reg, wr_addr_next;
  logic [11:0]       wr_data_reg, wr_data_next;
  logic              done_reg,    done_next;
  logic              error_reg,   error_next;

  logic in_frame;
  logic transfer;

  // Ready is a pure decode of the state register so that no combinational
  // path exists from rx_valid back to rx_ready.
  assign in_frame = (state_reg == ST_HI) || (state_reg == ST_LO);
  assign transfer = bus.rx_valid && in_frame;

  assign bus.rx_ready = in_frame;
  assign bus.busy     = in_frame;
  assign bus.wr_en    = wr_en_reg;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.done     = done_reg;
  assign bus.error    = error_reg;

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      r_reg       <= '0;
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_addr_reg <= '0;
      wr_data_reg <= '0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      r_reg       <= r_next;
      cnt_reg     <= cnt_next;
      wr_en_reg   <= wr_en_next;
      wr_addr_reg <= wr_addr_next;
      wr_data_reg <= wr_data_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    x_next       = x_reg;
    y_next       = y_reg;
    r_next       = r_reg;
    cnt_next     = cnt_reg;
    wr_en_next   = 1'b0;
    wr_addr_next = wr_addr_reg;   // address/data hold between writes
    wr_data_next = wr_data_reg;
    done_next    = 1'b0;
    error_next   = 1'b0;

    if (bus.abort) begin
      // Abort outranks start, a coincident transfer and timeout expiry. A byte
      // handshaken in this cycle is consumed but never written.
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_next = ST_HI;
            x_next     = '0;
            y_next     = '0;
            cnt_next   = '0;
          end
        end

        ST_HI: begin
          if (transfer) begin
            r_next     = bus.rx_data[3:0];
            cnt_next   = '0;
            state_next = ST_LO;
          end else if (cnt_reg == CNT_LAST) begin
            error_next = 1'b1;
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end

        ST_LO: begin
          if (transfer) begin
            wr_en_next   = 1'b1;
            wr_addr_next = {y_reg, x_reg};
            wr_data_next = {r_reg, bus.rx_data};
            cnt_next     = '0;
            state_next   = ST_HI;
            if (x_reg == X_LAST) begin
              x_next = '0;
              if (y_reg == Y_LAST) begin
                // Final pixel: done rides with its write strobe and the
                // frame closes on the same edge.
                done_next  = 1'b1;
                state_next = ST_IDLE;
              end else begin
                y_next = y_reg + 8'd1;
              end
            end else begin
              x_next = x_reg + 8'd1;
            end
          end else if (cnt_reg == CNT_LAST) begin
            error_next = 1'b1;
            cnt_next   = '0;
            state_next = ST_IDLE;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_image_ram_loader.sv
// -----------------------------------------------------------------------------
// tb_image_ram_loader
//   Self-checking bench for image_ram_loader with a 4x2 image and an 8-cycle
//   timeout. The stimulus side pushes the expected write (address derived from
//   the pixel index, data from the two bytes sent) when the second byte of a
//   pixel is handshaken; an independent monitor pops and compares on every
//   wr_en. Inputs change on the falling edge, outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_image_ram_loader;

  localparam int W   = 4;
  localparam int H   = 2;
  localparam int TO  = 8;
  localparam int FRAME_BYTES = 2 * W * H;

  typedef struct packed {
    logic [15:0] addr;
    logic [11:0] data;
    logic        last;
  } exp_t;

  logic pclk;
  logic rst;
  image_ram_loader_if bus();

  image_ram_loader #(
    .WIDTH(W),
    .HEIGHT(H),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk(pclk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   error_cnt = 0;
  int   frames_exp = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic prev_wr_en = 1'b0;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the oldest outstanding expectation.
  always @(negedge pclk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        chk("wr_en_single_cycle", prev_wr_en, 1'b0);
        chk("write_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", bus.wr_addr, mon_e.addr);
          chk("wr_data", bus.wr_data, mon_e.data);
          chk("done_with_write", bus.done, mon_e.last);
          $display("write addr=0x%04h data=0x%03h done=%0b", bus.wr_addr, bus.wr_data, bus.done);
        end
      end else if (bus.done) begin
        chk("done_without_write", bus.wr_en, 1'b1);
      end
      if (bus.done)  done_cnt++;
      if (bus.error) error_cnt++;
    end
    prev_wr_en = bus.wr_en;
  end

  // Present one byte from a falling edge until it is handshaken; optionally
  // push the write it should cause right after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b, input bit st, input bit push,
                           input exp_t e, input bit ab);
    int wait_n = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    bus.start    = st;
    bus.abort    = ab;
    while (!bus.rx_ready && wait_n < 20) begin
      @(negedge pclk);
      wait_n++;
    end
    chk("rx_ready_before_transfer", bus.rx_ready, 1'b1);
    if (bus.rx_ready) begin
      @(posedge pclk);
      if (push) exp_q.push_back(e);
      @(negedge pclk);
    end
    bus.rx_valid = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
  endtask

  // Start a frame and send nbytes; gap_max idle cycles between bytes at most;
  // start re-pulsed with byte start_at (to exercise start while busy).
  task automatic run_frame(input int nbytes, input int gap_max, input int start_at, input bit fixed);
    logic [7:0] b;
    logic [7:0] hi;
    exp_t e;
    int   idx;
    int   gap;
    hi = 8'h00;
    @(negedge pclk);
    bus.start = 1'b1;
    @(negedge pclk);
    bus.start = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
      repeat (gap) @(negedge pclk);
      if (fixed) b = (i % 2 == 0) ? 8'h0A : 8'h5C;
      else       b = 8'($urandom);
      idx    = i / 2;
      e.addr = {8'(idx / W), 8'(idx % W)};
      e.data = {hi[3:0], b};
      e.last = (idx == W * H - 1);
      send_byte(b, (i == start_at), (i % 2 == 1), e, 1'b0);
      if (i % 2 == 0) hi = b;
      $display("byte %0d = 0x%02h", i, b);
    end
  endtask

  task automatic finish_frame();
    frames_exp++;
    repeat (2) @(negedge pclk);
    chk("frame_done_count", done_cnt, frames_exp);
    chk("busy_after_frame", bus.busy, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic chk_zero_outputs();
    chk("rst_rx_ready", bus.rx_ready, 1'b0);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_wr_en",    bus.wr_en,    1'b0);
    chk("rst_wr_addr",  bus.wr_addr,  16'h0);
    chk("rst_wr_data",  bus.wr_data,  12'h0);
    chk("rst_done",     bus.done,     1'b0);
    chk("rst_error",    bus.error,    1'b0);
  endtask

  initial begin
    exp_t dummy;
    int   n;
    bit   found;
    dummy = '0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge pclk);
    chk_zero_outputs();
    rst = 1'b0;

    // Fixed pattern, back-to-back: 8 writes of 0xA5C, done on the 8th.
    run_frame(FRAME_BYTES, 0, -1, 1'b1);
    finish_frame();

    // Random data with random idle gaps below the timeout.
    repeat (3) begin
      run_frame(FRAME_BYTES, 4, -1, 1'b0);
      finish_frame();
    end

    // Reset in the middle of a frame, then restart from address 0.
    run_frame(5, 0, -1, 1'b0);
    repeat (2) @(negedge pclk);
    rst = 1'b1;
    @(negedge pclk);
    chk_zero_outputs();
    rst = 1'b0;
    run_frame(FRAME_BYTES, 2, -1, 1'b0);
    finish_frame();

    // Bytes offered in IDLE are refused; start while busy is ignored.
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h33;
    repeat (5) begin
      @(negedge pclk);
      chk("idle_rx_ready", bus.rx_ready, 1'b0);
    end
    bus.rx_valid = 1'b0;
    run_frame(FRAME_BYTES, 1, 7, 1'b0);
    finish_frame();

    // Abort and start together in IDLE: stays idle.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge pclk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start_idle_busy", bus.busy, 1'b0);

    // Abort after 3 pixels + 1 byte; restart from 0.
    run_frame(7, 0, -1, 1'b0);
    bus.abort = 1'b1;
    @(negedge pclk);
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 1'b0);
    repeat (3) @(negedge pclk);
    chk("abort_no_done", done_cnt, frames_exp);
    chk("abort_no_write", exp_q.size(), 0);
    run_frame(FRAME_BYTES, 0, -1, 1'b0);
    finish_frame();

    // Abort coinciding with the LO transfer: byte consumed, nothing written.
    run_frame(1, 0, -1, 1'b0);
    send_byte(8'h77, 1'b0, 1'b0, dummy, 1'b1);
    chk("abort_lo_wr_en", bus.wr_en, 1'b0);
    chk("abort_lo_busy", bus.busy, 1'b0);
    repeat (3) @(negedge pclk);

    // Timeout: one byte then silence. The accepting edge is E0; error is
    // registered on E8, so it is first seen at the 9th falling edge after E0.
    run_frame(1, 0, -1, 1'b0);
    n = 1;
    found = 1'b0;
    while (n <= 20 && !found) begin
      if (bus.error) found = 1'b1;
      else begin
        @(negedge pclk);
        n++;
      end
    end
    chk("timeout_latency", n, 9);
    chk("timeout_busy", bus.busy, 1'b0);
    chk("timeout_wr_en", bus.wr_en, 1'b0);
    @(negedge pclk);
    chk("timeout_error_one_cycle", bus.error, 1'b0);
    repeat (2) @(negedge pclk);
    chk("error_pulse_count", error_cnt, 1);
    chk("total_done_count", done_cnt, frames_exp);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
